seq_tx_101: RTL and testbench



---
 rtl/seq_link_pkg.sv | 15 +
 rtl/seq_tx_101.sv | 110 +++++++++++
 tb/tb_seq_tx_101.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_link_pkg.sv
// Definitions shared by both ends of the "101" serial link: FSM encoding and
// the frame marker, so transmitter and detector can never disagree on them.
package seq_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } link_state_e;

  localparam int MARKER_LEN = 3;
  localparam logic [MARKER_LEN-1:0] MARKER = 3'b101;

endpackage

// File: rtl/seq_tx_101.sv
// Bit-serial frame transmitter: 101 marker, DATA_W payload bits MSB-first,
// then GAP idle zeros. One word accepted per frame over valid/ready.
module seq_tx_101
  import seq_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done,
  output link_state_e       state
);

  // Handshake: a word transfers on any rising edge where din_valid && din_ready;
  // din_ready is high only in IDLE, and a valid seen outside IDLE is not queued.

  generate
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("seq_tx_101: DATA_W must be within 1..32");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
      $error("seq_tx_101: GAP must be within 1..15");
    end
  endgenerate

  localparam int CNT_TOP  = (DATA_W > MARKER_LEN) ? DATA_W : MARKER_LEN;
  localparam int CNT_SPAN = (GAP > CNT_TOP) ? GAP : CNT_TOP;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(MARKER_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     shreg;
  logic [MARKER_LEN-1:0] mark_sh;

  assign din_ready = (state == ST_IDLE);

  // Outputs are loaded one edge ahead: the value registered on a transition
  // edge is the bit shown during the first cycle of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      mark_sh    <= '0;
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (din_valid) begin
            state     <= ST_MARK;
            cnt       <= '0;
            shreg     <= din;
            tx_bit    <= MARKER[MARKER_LEN-1];
            mark_sh   <= MARKER << 1;
            tx_active <= 1'b1;
          end
        end
        ST_MARK: begin
          if (cnt == MARK_LAST) begin
            state      <= ST_DATA;
            cnt        <= '0;
            tx_bit     <= shreg[DATA_W-1];
            shreg      <= shreg << 1;
            frame_done <= (DATA_W == 1);
          end else begin
            cnt     <= cnt + 1'b1;
            tx_bit  <= mark_sh[MARKER_LEN-1];
            mark_sh <= mark_sh << 1;
          end
        end
        ST_DATA: begin
          if (cnt == DATA_LAST) begin
            state      <= ST_GAP;
            cnt        <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            tx_bit     <= shreg[DATA_W-1];
            shreg      <= shreg << 1;
            frame_done <= (cnt == DATA_PEN);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx_101.sv
// Bench for seq_tx_101: a default instance (8/2) and a corner instance (1/1),
// each checked every cycle against a queue of expected line cycles.
module tb_seq_tx_101;
  import seq_link_pkg::*;

  localparam int DW  = 8;
  localparam int GP  = 2;
  localparam int DWC = 1;
  localparam int GPC = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // DUT signals
  logic [DW-1:0]  din;
  logic           din_valid;
  logic           din_ready, tx_bit, tx_active, frame_done;
  link_state_e    state;
  logic [DWC-1:0] din_c;
  logic           din_valid_c;
  logic           din_ready_c, tx_bit_c, tx_active_c, frame_done_c;
  link_state_e    state_c;

  seq_tx_101 #(.DATA_W(DW), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx_bit(tx_bit), .tx_active(tx_active),
    .frame_done(frame_done), .state(state)
  );

  seq_tx_101 #(.DATA_W(DWC), .GAP(GPC)) dut_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .din_valid(din_valid_c),
    .din_ready(din_ready_c), .tx_bit(tx_bit_c), .tx_active(tx_active_c),
    .frame_done(frame_done_c), .state(state_c)
  );

  // checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: one entry per line cycle, {ready, active, done, bit}
  logic [3:0] exp_q[$];
  logic [3:0] exp_qc[$];
  logic [2:0] marker_bits = 3'b101;
  localparam logic [3:0] IDLE_CYCLE = 4'b1000;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (din_valid) begin
        for (int i = 0; i < 3; i++) exp_q.push_back({3'b010, marker_bits[2-i]});
        for (int i = 0; i < DW; i++) exp_q.push_back({1'b0, 1'b1, (i == DW-1), din[DW-1-i]});
        for (int i = 0; i < GP; i++) exp_q.push_back(4'b0000);
      end
    end else void'(exp_q.pop_front());
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) exp_qc.delete();
    else if (exp_qc.size() == 0) begin
      if (din_valid_c) begin
        for (int i = 0; i < 3; i++) exp_qc.push_back({3'b010, marker_bits[2-i]});
        for (int i = 0; i < DWC; i++) exp_qc.push_back({1'b0, 1'b1, (i == DWC-1), din_c[DWC-1-i]});
        for (int i = 0; i < GPC; i++) exp_qc.push_back(4'b0000);
      end
    end else void'(exp_qc.pop_front());
  end

  initial forever begin
    logic [3:0] e, ec;
    @(negedge clk);
    e  = (exp_q.size()  != 0) ? exp_q[0]  : IDLE_CYCLE;
    ec = (exp_qc.size() != 0) ? exp_qc[0] : IDLE_CYCLE;
    check("ready",    din_ready,  e[3]);
    check("active",   tx_active,  e[2]);
    check("done",     frame_done, e[1]);
    check("bit",      tx_bit,     e[0]);
    check("c_ready",  din_ready_c,  ec[3]);
    check("c_active", tx_active_c,  ec[2]);
    check("c_done",   frame_done_c, ec[1]);
    check("c_bit",    tx_bit_c,     ec[0]);
  end

  // loopback 101 detector and event counters on the main line
  logic [2:0] hist;
  int det_cnt = 0, det_cyc = -1, done_cnt = 0, done_cyc = -1;
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) hist = 3'b000;
    else begin
      hist = {hist[1:0], tx_bit};
      if (hist == 3'b101) begin
        det_cnt++;
        det_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] w, output int acc);
    logic r;
    int n = 0;
    din = w;
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = din_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    #1;
    din_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic send_c(input logic [DWC-1:0] w, output int acc);
    logic r;
    int n = 0;
    din_c = w;
    din_valid_c = 1'b1;
    forever begin
      @(negedge clk);
      r = din_ready_c;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 200) begin
        check("send_c_timeout", 1, 0);
        break;
      end
    end
    #1;
    din_valid_c = 1'b0;
    acc = cyc;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // stimulus
  initial begin
    int a1, a2, snap_det, snap_done;
    logic [DW-1:0] w;
    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    din_c = '0;
    din_valid_c = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_ready",  din_ready,  1);
    check("rst_bit",    tx_bit,     0);
    check("rst_active", tx_active,  0);
    check("rst_done",   frame_done, 0);
    check("rst_state",  state,      ST_IDLE);
    idle_cycles(2);

    // basic frame
    send(8'hA5, a1);
    din = 8'h00;
    idle_cycles(15);
    check("basic_done_cycle", done_cyc, a1 + DW + 2);

    // back-to-back
    send(8'hFF, a1);
    send(8'h00, a2);
    check("b2b_period", a2 - a1, 4 + DW + GP);
    idle_cycles(16);

    // ignored request during DATA
    snap_done = done_cnt;
    send(8'hC3, a1);
    repeat (5) @(posedge clk);
    #1;
    din = 8'h3C;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    idle_cycles(25);
    check("ignored_one_frame", done_cnt - snap_done, 1);

    // asynchronous reset during the third data bit
    snap_done = done_cnt;
    send(8'h5A, a1);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_active", tx_active, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bit",    tx_bit,     0);
    check("mid_rst_active", tx_active,  0);
    check("mid_rst_done",   frame_done, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", din_ready, 1);
    idle_cycles(20);
    check("post_rst_no_done", done_cnt - snap_done, 0);

    // loopback through the 101 detector
    snap_det = det_cnt;
    send(8'h00, a1);
    idle_cycles(16);
    check("loop00_count", det_cnt - snap_det, 1);
    check("loop00_cycle", det_cyc, a1 + 2);
    snap_det = det_cnt;
    send(8'h12, a1);
    idle_cycles(16);
    check("loop12_count", det_cnt - snap_det, 1);
    check("loop12_cycle", det_cyc, a1 + 2);

    // randomized frames with random idle spacing and din churn mid-frame
    for (int k = 0; k < 30; k++) begin
      w = DW'($urandom);
      send(w, a1);
      din = DW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        idle_cycles(14);
      end else begin
        idle_cycles($urandom_range(0, 3));
      end
    end
    idle_cycles(16);

    // parameter corner: DATA_W = 1, GAP = 1
    send_c(1'b1, a1);
    send_c(1'b1, a2);
    check("corner_period", a2 - a1, 4 + DWC + GPC);
    for (int k = 0; k < 10; k++) begin
      send_c(DWC'($urandom), a1);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
